// File: rtl/fsm_tx.sv
// UART transmit control FSM with triple-redundant state, counter and config.
// Each cycle all copies reload from the voted value, which scrubs single-copy upsets.
module fsm_tx #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Tx_Start_i,
    input  logic       Bit_Tick_i,
    input  logic       Parity_En_i,
    input  logic       Stop_Two_i,
    output logic [4:0] State_o,
    output logic [3:0] BitCounter_o,
    output logic       Load_o,
    output logic       Shift_o,
    output logic       TxDone_o,
    output logic       Vote_Err_o
);
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic [4:0] r_state_a, r_state_b, r_state_c;
    logic [3:0] r_cnt_a, r_cnt_b, r_cnt_c;
    logic       r_par_a, r_par_b, r_par_c;
    logic       r_stop2_a, r_stop2_b, r_stop2_c;
    logic       r_load, r_shift, r_done, r_vote_err;

    logic [4:0] w_state_v;
    logic [3:0] w_cnt_v;
    logic       w_par_v, w_stop2_v;
    logic       w_mismatch;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_par_nxt, w_stop2_nxt;
    logic       w_load_nxt, w_shift_nxt, w_done_nxt;

    assign w_state_v = (r_state_a & r_state_b) | (r_state_a & r_state_c) | (r_state_b & r_state_c);
    assign w_cnt_v   = (r_cnt_a & r_cnt_b) | (r_cnt_a & r_cnt_c) | (r_cnt_b & r_cnt_c);
    assign w_par_v   = (r_par_a & r_par_b) | (r_par_a & r_par_c) | (r_par_b & r_par_c);
    assign w_stop2_v = (r_stop2_a & r_stop2_b) | (r_stop2_a & r_stop2_c) | (r_stop2_b & r_stop2_c);

    // Any copy differing from copy A on any bit means the three do not all agree.
    assign w_mismatch =
        (|({r_state_a, r_cnt_a, r_par_a, r_stop2_a} ^ {r_state_b, r_cnt_b, r_par_b, r_stop2_b})) |
        (|({r_state_a, r_cnt_a, r_par_a, r_stop2_a} ^ {r_state_c, r_cnt_c, r_par_c, r_stop2_c}));

    always_comb begin
        w_state_nxt = state_t'(w_state_v);
        w_cnt_nxt   = w_cnt_v;
        w_par_nxt   = w_par_v;
        w_stop2_nxt = w_stop2_v;
        w_load_nxt  = 1'b0;
        w_shift_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_v)
            S_IDLE: begin
                if (Bit_Tick_i && Tx_Start_i) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = Parity_En_i;
                    w_stop2_nxt = Stop_Two_i;
                    w_load_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (Bit_Tick_i) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (Bit_Tick_i) begin
                    w_shift_nxt = 1'b1;
                    if (w_cnt_v < LAST_BIT) begin
                        w_cnt_nxt = w_cnt_v + 4'd1;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_par_v ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (Bit_Tick_i) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = '0;
                end
            end
            S_STOP: begin
                if (Bit_Tick_i) begin
                    if (w_stop2_v && (w_cnt_v == 4'd0)) begin
                        w_cnt_nxt = 4'd1;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                        // Back-to-back frame skips IDLE and latches fresh config.
                        if (Tx_Start_i) begin
                            w_state_nxt = S_START;
                            w_load_nxt  = 1'b1;
                            w_par_nxt   = Parity_En_i;
                            w_stop2_nxt = Stop_Two_i;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_a  <= S_IDLE;
            r_state_b  <= S_IDLE;
            r_state_c  <= S_IDLE;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_cnt_c    <= '0;
            r_par_a    <= 1'b0;
            r_par_b    <= 1'b0;
            r_par_c    <= 1'b0;
            r_stop2_a  <= 1'b0;
            r_stop2_b  <= 1'b0;
            r_stop2_c  <= 1'b0;
            r_load     <= 1'b0;
            r_shift    <= 1'b0;
            r_done     <= 1'b0;
            r_vote_err <= 1'b0;
        end else begin
            r_state_a  <= w_state_nxt;
            r_state_b  <= w_state_nxt;
            r_state_c  <= w_state_nxt;
            r_cnt_a    <= w_cnt_nxt;
            r_cnt_b    <= w_cnt_nxt;
            r_cnt_c    <= w_cnt_nxt;
            r_par_a    <= w_par_nxt;
            r_par_b    <= w_par_nxt;
            r_par_c    <= w_par_nxt;
            r_stop2_a  <= w_stop2_nxt;
            r_stop2_b  <= w_stop2_nxt;
            r_stop2_c  <= w_stop2_nxt;
            r_load     <= w_load_nxt;
            r_shift    <= w_shift_nxt;
            r_done     <= w_done_nxt;
            r_vote_err <= w_mismatch;
        end
    end

    assign State_o      = w_state_v;
    assign BitCounter_o = w_cnt_v;
    assign Load_o       = r_load;
    assign Shift_o      = r_shift;
    assign TxDone_o     = r_done;
    assign Vote_Err_o   = r_vote_err;
endmodule
